// File: rtl/l5_ram_fifo_ctrl.sv
// FIFO controller wrapping a 256x32 single-port RAM with valid/ready on both sides.
// A single-port FSM serialises RAM writes and reads; a one-word output register presents the head word.
module l5_ram_fifo_ctrl #(
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [AW:0]   level,
  output logic [AW-1:0] ram_a,
  output logic          ram_cs,
  output logic          ram_oe,
  output logic          ram_we,
  output logic [DW-1:0] ram_di,
  input  logic [DW-1:0] ram_dout
);

  localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {IDLE, WRITE, RD_ADDR, RD_CAP} state_t;

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          rd_go;

  // Refilling the empty output register beats accepting a new word.
  assign rd_go   = (cnt != '0) && !m_valid;
  assign s_ready = rst_n && (state == IDLE) && (cnt < FULL) && !rd_go;
  assign level   = cnt + {{AW{1'b0}}, m_valid};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      ram_a   <= '0;
      ram_cs  <= 1'b0;
      ram_oe  <= 1'b0;
      ram_we  <= 1'b0;
      ram_di  <= '0;
    end else begin
      if (m_valid && m_ready) m_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_go) begin
            state  <= RD_ADDR;
            ram_a  <= rd_ptr;
            ram_cs <= 1'b1;
            ram_oe <= 1'b1;
            ram_we <= 1'b0;
          end else if (s_valid && s_ready) begin
            state  <= WRITE;
            ram_a  <= wr_ptr;
            ram_di <= s_data;
            ram_cs <= 1'b1;
            ram_oe <= 1'b0;
            ram_we <= 1'b1;
          end
        end
        WRITE: begin
          wr_ptr <= wr_ptr + AW'(1);
          cnt    <= cnt + (AW+1)'(1);
          ram_cs <= 1'b0;
          ram_we <= 1'b0;
          state  <= IDLE;
        end
        RD_ADDR: begin
          state <= RD_CAP;
        end
        RD_CAP: begin
          // Sampling after two cycles of stable address covers both comb and registered RAM reads.
          m_data  <= ram_dout;
          m_valid <= 1'b1;
          rd_ptr  <= rd_ptr + AW'(1);
          cnt     <= cnt - (AW+1)'(1);
          ram_cs  <= 1'b0;
          ram_oe  <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l5_ram_fifo_ctrl.sv
// Self-checking bench for l5_ram_fifo_ctrl with a registered-read RAM model and a queue reference.
module tb_l5_ram_fifo_ctrl;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [8:0]  level;
  logic [7:0]  ram_a;
  logic        ram_cs;
  logic        ram_oe;
  logic        ram_we;
  logic [31:0] ram_di;
  logic [31:0] ram_dout;

  int checks;
  int failures;

  logic [31:0] exp_q[$];
  int          acc_prev;
  logic [31:0] mem [256];

  l5_ram_fifo_ctrl #(.DW(32), .AW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .level(level),
    .ram_a(ram_a), .ram_cs(ram_cs), .ram_oe(ram_oe), .ram_we(ram_we),
    .ram_di(ram_di), .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read single-port RAM
  always @(posedge clk) begin
    if (ram_cs && ram_we) mem[ram_a] <= ram_di;
    if (ram_cs && ram_oe) ram_dout <= mem[ram_a];
  end

  // One clock: drive at negedge, sample there, let the edge happen, update the model, return 1 time unit later.
  task automatic step(input logic sv, input logic [31:0] sd, input logic mr,
                      output logic acc, output logic pop, output logic [31:0] pd,
                      output logic [31:0] pe, output int lvl_o, output int lvl_e);
    @(negedge clk);
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    acc   = (s_valid && s_ready) === 1'b1;
    pop   = (m_valid && m_ready) === 1'b1;
    pd    = m_data;
    pe    = (exp_q.size() > 0) ? exp_q[0] : 32'hxxxxxxxx;
    lvl_o = int'(level);
    lvl_e = exp_q.size() - acc_prev;
    @(posedge clk);
    if (!rst_n) begin
      exp_q.delete();
      acc_prev = 0;
    end else begin
      if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(sd);
      acc_prev = acc ? 1 : 0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b1; s_data = 32'h11111111; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready got %b want 0", s_ready); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
    checks++; if (level !== 9'd0) begin failures++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if ({ram_cs, ram_we, ram_oe} !== 3'b000) begin failures++; $display("FAIL reset_ram_ctl got %b want 000", {ram_cs, ram_we, ram_oe}); end
    @(negedge clk);
    rst_n = 1'b1; s_valid = 1'b0;
    exp_q.delete(); acc_prev = 0;
  endtask

  task automatic test_single_push();
    logic acc, pop; logic [31:0] pd, pe; int lo, le, t;
    t = 0; acc = 1'b0;
    while (!acc && t < 20) begin step(1'b1, 32'hDEADBEEF, 1'b0, acc, pop, pd, pe, lo, le); t++; end
    checks++; if (!acc) begin failures++; $display("FAIL single_accept_timeout got none want accept"); end
    checks++; if ({ram_cs, ram_we, ram_oe} !== 3'b110) begin failures++; $display("FAIL single_write_ctl got %b want 110", {ram_cs, ram_we, ram_oe}); end
    checks++; if (ram_a !== 8'd0) begin failures++; $display("FAIL single_write_addr got %0d want 0", ram_a); end
    checks++; if (ram_di !== 32'hDEADBEEF) begin failures++; $display("FAIL single_write_di got %h want deadbeef", ram_di); end
    repeat (3) step(1'b0, 32'h0, 1'b0, acc, pop, pd, pe, lo, le);
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got %b want 0 at T+4", m_valid); end
    step(1'b0, 32'h0, 1'b0, acc, pop, pd, pe, lo, le);
    checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL single_latency got %b want 1 at T+5", m_valid); end
    checks++; if (m_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_m_data got %h want deadbeef", m_data); end
    checks++; if (level !== 9'd1) begin failures++; $display("FAIL single_level got %0d want 1", level); end
    step(1'b0, 32'h0, 1'b1, acc, pop, pd, pe, lo, le);
    checks++; if (!pop || pd !== 32'hDEADBEEF) begin failures++; $display("FAIL single_pop got pop=%b data=%h want pop=1 data=deadbeef", pop, pd); end
  endtask

  task automatic test_fill_drain();
    logic acc, pop; logic [31:0] pd, pe; int lo, le, t, n, ev, lvl_bad, acc_late;
    n = 0; t = 0; lvl_bad = 0;
    while (n < 257 && t < 2000) begin
      step(1'b1, n, 1'b0, acc, pop, pd, pe, lo, le);
      if (lo != le) lvl_bad++;
      if (acc) n++;
      t++;
    end
    checks++; if (n != 257) begin failures++; $display("FAIL fill_count got %0d want 257", n); end
    checks++; if (lvl_bad != 0) begin failures++; $display("FAIL fill_level_track got %0d bad cycles want 0", lvl_bad); end
    acc_late = 0;
    repeat (10) begin step(1'b1, 32'd999, 1'b0, acc, pop, pd, pe, lo, le); if (acc) acc_late++; end
    checks++; if (acc_late != 0) begin failures++; $display("FAIL full_accept got %0d want 0", acc_late); end
    checks++; if (level !== 9'd257) begin failures++; $display("FAIL full_level got %0d want 257", level); end
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL full_s_ready got %b want 0", s_ready); end
    ev = 0; t = 0;
    while (ev < 257 && t < 3000) begin
      step(1'b0, 32'h0, 1'b1, acc, pop, pd, pe, lo, le);
      if (pop) begin
        checks++; if (pd !== ev) begin failures++; $display("FAIL drain_order got %0d want %0d", pd, ev); end
        ev++;
      end
      t++;
    end
    checks++; if (ev != 257) begin failures++; $display("FAIL drain_count got %0d want 257", ev); end
    step(1'b0, 32'h0, 1'b1, acc, pop, pd, pe, lo, le);
    checks++; if (level !== 9'd0) begin failures++; $display("FAIL drain_level got %0d want 0", level); end
  endtask

  task automatic test_stream();
    logic acc, pop; logic [31:0] pd, pe; int lo, le, t, nxt, got, lvl_bad, ord_bad;
    logic sv, mr; int last_wa, last_ra; logic wwrap, rwrap;
    nxt = 0; got = 0; t = 0; lvl_bad = 0; ord_bad = 0;
    last_wa = -1; last_ra = -1; wwrap = 1'b0; rwrap = 1'b0;
    while (got < 600 && t < 20000) begin
      sv = (nxt < 600) && ($urandom_range(0, 3) != 0);
      mr = ($urandom_range(0, 2) != 0);
      step(sv, 32'h1000_0000 + nxt, mr, acc, pop, pd, pe, lo, le);
      if (lo != le) lvl_bad++;
      if (acc) nxt++;
      if (pop) begin
        if (pd !== 32'h1000_0000 + got) ord_bad++;
        got++;
      end
      if (ram_cs && ram_we) begin
        if (last_wa == 255 && ram_a == 8'd0) wwrap = 1'b1;
        last_wa = int'(ram_a);
      end
      if (ram_cs && ram_oe) begin
        if (last_ra == 255 && ram_a == 8'd0) rwrap = 1'b1;
        last_ra = int'(ram_a);
      end
      t++;
    end
    checks++; if (got != 600) begin failures++; $display("FAIL stream_count got %0d want 600", got); end
    checks++; if (ord_bad != 0) begin failures++; $display("FAIL stream_order got %0d bad words want 0", ord_bad); end
    checks++; if (lvl_bad != 0) begin failures++; $display("FAIL stream_level got %0d bad cycles want 0", lvl_bad); end
    checks++; if (!wwrap) begin failures++; $display("FAIL stream_wr_wrap got 0 want 1"); end
    checks++; if (!rwrap) begin failures++; $display("FAIL stream_rd_wrap got 0 want 1"); end
  endtask

  task automatic test_reset_midwrite();
    logic acc, pop; logic [31:0] pd, pe; int lo, le, t;
    t = 0; acc = 1'b0;
    while (!acc && t < 40) begin step(1'b1, 32'hA5A5A5A5, 1'b0, acc, pop, pd, pe, lo, le); t++; end
    checks++; if (!(acc && ram_we === 1'b1)) begin failures++; $display("FAIL midrst_in_write got acc=%b we=%b want 1 1", acc, ram_we); end
    rst_n = 1'b0; s_valid = 1'b0;
    @(posedge clk); #1;
    exp_q.delete(); acc_prev = 0;
    checks++; if ({ram_cs, ram_we, ram_oe} !== 3'b000) begin failures++; $display("FAIL midrst_ctl got %b want 000", {ram_cs, ram_we, ram_oe}); end
    checks++; if (level !== 9'd0) begin failures++; $display("FAIL midrst_level got %0d want 0", level); end
    rst_n = 1'b1;
    t = 0; acc = 1'b0;
    while (!acc && t < 20) begin step(1'b1, 32'h12345678, 1'b0, acc, pop, pd, pe, lo, le); t++; end
    checks++; if (!(acc && ram_we === 1'b1 && ram_a === 8'd0)) begin failures++; $display("FAIL midrst_addr got we=%b a=%0d want we=1 a=0", ram_we, ram_a); end
    t = 0;
    while (m_valid !== 1'b1 && t < 20) begin step(1'b0, 32'h0, 1'b0, acc, pop, pd, pe, lo, le); t++; end
    checks++; if (m_valid !== 1'b1 || m_data !== 32'h12345678) begin failures++; $display("FAIL midrst_readback got %h want 12345678", m_data); end
    step(1'b0, 32'h0, 1'b1, acc, pop, pd, pe, lo, le);
  endtask

  task automatic test_hold();
    logic acc, pop; logic [31:0] pd, pe; int lo, le, t, chg, ev_bad, n;
    t = 0; acc = 1'b0;
    while (!acc && t < 20) begin step(1'b1, 32'hCAFE0000, 1'b0, acc, pop, pd, pe, lo, le); t++; end
    t = 0;
    while (m_valid !== 1'b1 && t < 20) begin step(1'b0, 32'h0, 1'b0, acc, pop, pd, pe, lo, le); t++; end
    chg = 0;
    repeat (20) begin
      step(1'b1, $urandom, 1'b0, acc, pop, pd, pe, lo, le);
      if (m_data !== 32'hCAFE0000 || m_valid !== 1'b1) chg++;
    end
    checks++; if (chg != 0) begin failures++; $display("FAIL hold_m_data got %0d changed cycles want 0", chg); end
    t = 0;
    while (level !== 9'd257 && t < 1500) begin
      step(1'b1, $urandom, 1'b0, acc, pop, pd, pe, lo, le);
      if (m_data !== 32'hCAFE0000) chg++;
      t++;
    end
    repeat (4) step(1'b1, $urandom, 1'b0, acc, pop, pd, pe, lo, le);
    checks++; if (level !== 9'd257 || s_ready !== 1'b0) begin failures++; $display("FAIL hold_full got level=%0d s_ready=%b want 257 0", level, s_ready); end
    checks++; if (chg != 0 || m_data !== 32'hCAFE0000) begin failures++; $display("FAIL hold_stable got %h want cafe0000", m_data); end
    ev_bad = 0; n = 0; t = 0;
    while (level !== 9'd0 && t < 3000) begin
      step(1'b0, 32'h0, $urandom_range(0, 1), acc, pop, pd, pe, lo, le);
      if (pop) begin if (pd !== pe) ev_bad++; n++; end
      t++;
    end
    checks++; if (ev_bad != 0 || n != 257) begin failures++; $display("FAIL hold_drain got bad=%0d pops=%0d want 0 257", ev_bad, n); end
  endtask

  initial begin
    checks = 0; failures = 0; acc_prev = 0;
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    test_reset();
    test_single_push();
    test_fill_drain();
    test_stream();
    test_reset_midwrite();
    test_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
